// File: rtl/stepdir_decoder_pkg.sv
// stepdir_decoder_pkg: shared widths and state encoding for the step/dir decoder
package stepdir_decoder_pkg;
   localparam int POS_WIDTH = 32;
   localparam int FILT_W    = 8;
   typedef enum logic [1:0] {IDLE, FIRST, RUN} state_t;
endpackage

// File: rtl/stepdir_decoder_if.sv
// stepdir_decoder_if: control/status bundle between a host and the decoder
interface stepdir_decoder_if;
   import stepdir_decoder_pkg::*;
   logic                        step;
   logic                        dir;
   logic                        enable;
   logic                        pos_load;
   logic signed [POS_WIDTH-1:0] pos_value;
   logic                        err_clear;
   logic signed [POS_WIDTH-1:0] position;
   logic [31:0]                 period;
   logic                        period_valid;
   logic                        dir_error;
   modport master (
      output step, dir, enable, pos_load, pos_value, err_clear,
      input  position, period, period_valid, dir_error
   );
   modport slave (
      input  step, dir, enable, pos_load, pos_value, err_clear,
      output position, period, period_valid, dir_error
   );
endinterface

// File: rtl/stepdir_decoder_input_filter.sv
// input_filter: 2-FF synchroniser followed by a FILTER-cycle stability filter
module input_filter
   import stepdir_decoder_pkg::*;
#(
   parameter int unsigned FILTER = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level
);
   logic [1:0]        sync_q, sync_d;
   logic [FILT_W-1:0] cnt_q, cnt_d;
   logic              level_q, level_d;
   logic              differ, flip;

   always_comb begin
      sync_d  = {sync_q[0], din};
      differ  = sync_q[1] ^ level_q;
      flip    = differ && cnt_q == FILT_W'(FILTER - 1);
      cnt_d   = (differ && !flip) ? cnt_q + 1'b1 : '0;
      level_d = flip ? sync_q[1] : level_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level = level_q;
endmodule

// File: rtl/stepdir_decoder.sv
// stepdir_decoder: filtered step/dir pins to signed position, step period and dir-setup checking
module stepdir_decoder
   import stepdir_decoder_pkg::*;
#(
   parameter int unsigned FILTER     = 4,
   parameter int unsigned DIR_SETUP  = 18,
   parameter int unsigned TIMEOUT    = 27000000,
   parameter bit          DIR_INVERT = 1'b0
) (
   input logic clk,
   input logic rst,
   stepdir_decoder_if.slave bus
);
   localparam int WARM_W = FILT_W + 1;
   localparam logic [WARM_W-1:0] WARM = WARM_W'(FILTER + 2);

   logic                 step_f, dir_f;
   logic                 step_prev_q, dir_prev_q;
   logic                 arm_q, arm_d;
   logic [WARM_W-1:0]    warm_q, warm_d;
   logic [POS_WIDTH-1:0] position_q, position_d;
   logic [31:0]          period_q, period_d, gap_q, gap_d, setup_q, setup_d;
   logic                 period_valid_q, period_valid_d, dir_error_q, dir_error_d;
   state_t               state_q, state_d, cur;
   logic                 cnt_edge, dir_chg, timed_out, up;

   input_filter #(.FILTER(FILTER)) u_step (.clk(clk), .rst(rst), .din(bus.step), .level(step_f));
   input_filter #(.FILTER(FILTER)) u_dir  (.clk(clk), .rst(rst), .din(bus.dir),  .level(dir_f));

   // A pin already high at reset reaches the filtered level once the pipeline has
   // filled; counting stays disarmed until the filtered step has been seen low.
   always_comb begin
      warm_d         = warm_q == WARM ? warm_q : warm_q + 1'b1;
      arm_d          = arm_q | (warm_q == WARM && !step_f);
      cnt_edge       = bus.enable & arm_q & step_f & ~step_prev_q;
      dir_chg        = dir_f ^ dir_prev_q;
      up             = dir_f ^ DIR_INVERT;
      timed_out      = state_q != IDLE && gap_q == TIMEOUT;
      cur            = timed_out ? IDLE : state_q;
      state_d        = cnt_edge ? (cur == IDLE ? FIRST : RUN) : cur;
      period_d       = timed_out ? '0 : (cnt_edge && cur != IDLE) ? gap_q + 32'd1 : period_q;
      period_valid_d = state_d == RUN;
      gap_d          = cnt_edge ? '0 : gap_q == TIMEOUT ? gap_q : gap_q + 32'd1;
      setup_d        = dir_chg ? '0 : setup_q == DIR_SETUP ? setup_q : setup_q + 32'd1;
      dir_error_d    = (cnt_edge & (dir_chg | (setup_q < DIR_SETUP))) | (dir_error_q & ~bus.err_clear);
      position_d     = bus.pos_load ? bus.pos_value :
                       cnt_edge ? position_q + (up ? 32'd1 : 32'hFFFF_FFFF) : position_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         step_prev_q    <= 1'b0;
         dir_prev_q     <= 1'b0;
         arm_q          <= 1'b0;
         warm_q         <= '0;
         position_q     <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         dir_error_q    <= 1'b0;
         gap_q          <= '0;
         setup_q        <= '0;
         state_q        <= IDLE;
      end else begin
         step_prev_q    <= step_f;
         dir_prev_q     <= dir_f;
         arm_q          <= arm_d;
         warm_q         <= warm_d;
         position_q     <= position_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         dir_error_q    <= dir_error_d;
         gap_q          <= gap_d;
         setup_q        <= setup_d;
         state_q        <= state_d;
      end
   end

   assign bus.position     = position_q;
   assign bus.period       = period_q;
   assign bus.period_valid = period_valid_q;
   assign bus.dir_error    = dir_error_q;
endmodule

// File: tb/tb_stepdir_decoder.sv
// tb_stepdir_decoder: vector table plus latency-tracking scoreboard for stepdir_decoder
module tb_stepdir_decoder;
   import stepdir_decoder_pkg::*;
   localparam int FILTER = 4, DIR_SETUP = 18, TIMEOUT = 1000, LAT = FILTER + 3;

   typedef struct {int due; logic [31:0] pos;} sb_t;
   typedef struct {logic dir; int n; int hi; int lo; logic [31:0] pos; logic [31:0] period; logic valid;} vec_t;

   logic        clk = 1'b0, rst = 1'b1;
   int          cyc = 0, checks = 0, failures = 0;
   logic [31:0] model_pos = '0;
   sb_t         sb[$];
   vec_t        vecs[4];

   stepdir_decoder_if bus();
   stepdir_decoder #(.FILTER(FILTER), .DIR_SETUP(DIR_SETUP), .TIMEOUT(TIMEOUT), .DIR_INVERT(1'b0))
      dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_step();
      bus.step = 1'b1;
      if (bus.enable) begin
         model_pos = model_pos + (bus.dir ? 32'd1 : 32'hFFFF_FFFF);
         sb.push_back('{due: cyc + LAT, pos: model_pos});
      end
   endtask

   task automatic pulse(input int hi, input int lo);
      start_step();
      tick(hi);
      bus.step = 1'b0;
      tick(lo);
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_period"}, bus.period, 32'd0);
      chk({name, "_valid"}, {31'd0, bus.period_valid}, 32'd0);
      chk({name, "_state"}, 32'(dut.state_q), 32'(IDLE));
   endtask

   // Each counted edge must show up exactly LAT cycles after its pin edge.
   always @(negedge clk) begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
         chk("sb_pos", bus.position, sb[0].pos);
         void'(sb.pop_front());
      end
   end

   initial begin
      vecs[0] = '{1'b1, 10, 20, 30, 32'd10, 32'd50, 1'b1};
      vecs[1] = '{1'b1,  3, 10, 15, 32'd13, 32'd25, 1'b1};
      vecs[2] = '{1'b0,  4,  8, 12, 32'd9,  32'd20, 1'b1};
      vecs[3] = '{1'b1,  2,  6,  6, 32'd11, 32'd12, 1'b1};
      bus.step = 0; bus.dir = 0; bus.enable = 1; bus.pos_load = 0; bus.pos_value = '0; bus.err_clear = 0;
      tick(3);
      chk("rst_pos", bus.position, 32'd0);
      chk("rst_err", {31'd0, bus.dir_error}, 32'd0);
      chk_idle("rst");
      rst = 1'b0;
      tick(10);

      bus.step = 1'b1;
      tick(3);
      bus.step = 1'b0;
      tick(20);
      chk("glitch_pos", bus.position, 32'd0);
      chk_idle("glitch");

      for (int i = 0; i < 4; i++) begin
         if (bus.dir !== vecs[i].dir) begin
            bus.dir = vecs[i].dir;
            tick(40);
         end
         for (int k = 0; k < vecs[i].n; k++) pulse(vecs[i].hi, vecs[i].lo);
         tick(10);
         chk($sformatf("vec%0d_pos", i), bus.position, vecs[i].pos);
         chk($sformatf("vec%0d_period", i), bus.period, vecs[i].period);
         chk($sformatf("vec%0d_valid", i), {31'd0, bus.period_valid}, {31'd0, vecs[i].valid});
         chk($sformatf("vec%0d_err", i), {31'd0, bus.dir_error}, 32'd0);
      end

      bus.enable = 1'b0;
      pulse(20, 30);
      chk("disabled_pos", bus.position, 32'd11);
      bus.enable = 1'b1;
      tick(5);

      bus.pos_value = 32'h7FFF_FFFF;
      bus.pos_load = 1'b1;
      tick();
      bus.pos_load = 1'b0;
      model_pos = 32'h7FFF_FFFF;
      chk("load_pos", bus.position, 32'h7FFF_FFFF);
      pulse(20, 30);
      chk("wrap_up", bus.position, 32'h8000_0000);
      bus.dir = 1'b0;
      tick(40);
      pulse(20, 30);
      chk("wrap_down", bus.position, 32'h7FFF_FFFF);
      chk("wrap_err", {31'd0, bus.dir_error}, 32'd0);

      bus.dir = 1'b1;
      tick(5);
      pulse(20, 30);
      chk("setup_pos", bus.position, 32'h8000_0000);
      chk("setup_err_set", {31'd0, bus.dir_error}, 32'd1);
      bus.err_clear = 1'b1;
      tick();
      bus.err_clear = 1'b0;
      chk("setup_err_clr", {31'd0, bus.dir_error}, 32'd0);

      pulse(20, 30);
      pulse(20, 30);
      bus.step = 1'b1;
      tick(FILTER + 2);
      bus.pos_value = 32'h0000_1234;
      bus.pos_load = 1'b1;
      tick();
      bus.pos_load = 1'b0;
      model_pos = 32'h0000_1234;
      chk("load_wins", bus.position, 32'h0000_1234);
      tick(13);
      bus.step = 1'b0;
      tick(30);
      chk("load_period", bus.period, 32'd50);
      chk("load_valid", {31'd0, bus.period_valid}, 32'd1);
      chk("load_hold", bus.position, 32'h0000_1234);

      pulse(20, 30);
      pulse(20, 30);
      chk("pre_to_period", bus.period, 32'd50);
      tick(TIMEOUT);
      chk_idle("timeout");

      bus.dir = 1'b0;
      tick(5);
      start_step();
      tick(10);
      chk("mid_pos", bus.position, model_pos);
      chk("mid_err", {31'd0, bus.dir_error}, 32'd1);
      rst = 1'b1;
      tick();
      chk("mid_rst_pos", bus.position, 32'd0);
      chk("mid_rst_err", {31'd0, bus.dir_error}, 32'd0);
      chk_idle("mid_rst");
      rst = 1'b0;
      model_pos = '0;
      tick(30);
      chk("held_high_pos", bus.position, 32'd0);
      chk("held_high_state", 32'(dut.state_q), 32'(IDLE));
      bus.step = 1'b0;
      tick(40);
      pulse(20, 30);
      chk("post_rst_down", bus.position, 32'hFFFF_FFFF);
      chk("sb_drained", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
